ex_mem_reg: RTL and testbench

- EX/MEM pipeline register of the 5-stage MIPS core. Sits directly downstream of the ALU.
- Captures the ALU result, the zero flag, store data, destination register and memory/writeback controls each cycle.
- Resolves BEQ/BNE from the ALU zero flag and presents a registered branch-taken/target pair to fetch.
- Exposes a forwarding tap for the operand-forwarding muxes that feed the ALU.

---
 rtl/ex_mem_reg.sv | 92 +++++++++
 tb/tb_ex_mem_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU output and MEM/WB controls, resolves
// BEQ/BNE into a registered taken/target pair, and drives the forwarding tap.
module ex_mem_reg #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_result,
  input  logic          ex_zero,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_dest_reg,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_branch,
  input  logic          ex_branch_ne,
  input  logic [DW-1:0] ex_pc_plus4,
  input  logic [DW-1:0] ex_imm_sext,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_result,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_dest_reg,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_reg,
  output logic [DW-1:0] fwd_data
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] store_data;
    logic [RW-1:0] dest_reg;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          br_taken;
    logic [DW-1:0] br_target;
  } mem_st_t;

  mem_st_t st_q, st_d;

  // Next-state: flush squashes to all-zero, stall holds, otherwise capture EX.
  // Controls are gated by ex_valid so a bubble never writes or branches;
  // writes to $0 are dropped here so downstream never sees them.
  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d = '0;
    end else if (!stall) begin
      st_d.valid      = ex_valid;
      st_d.alu_result = ex_alu_result;
      st_d.store_data = ex_store_data;
      st_d.dest_reg   = ex_dest_reg;
      st_d.reg_write  = ex_valid & ex_reg_write & (ex_dest_reg != '0);
      st_d.mem_read   = ex_valid & ex_mem_read;
      st_d.mem_write  = ex_valid & ex_mem_write;
      st_d.br_taken   = ex_valid & ex_branch & (ex_zero ^ ex_branch_ne);
      st_d.br_target  = ex_pc_plus4 + (ex_imm_sext << 2);
    end
  end

  // State register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= '0;
    else     st_q <= st_d;
  end

  assign mem_valid      = st_q.valid;
  assign mem_alu_result = st_q.alu_result;
  assign mem_store_data = st_q.store_data;
  assign mem_dest_reg   = st_q.dest_reg;
  assign mem_reg_write  = st_q.reg_write;
  assign mem_mem_read   = st_q.mem_read;
  assign mem_mem_write  = st_q.mem_write;
  assign branch_taken   = st_q.br_taken;
  assign branch_target  = st_q.br_target;

  // A load's ALU result is only an address, so it is never forwarded.
  assign fwd_valid = st_q.valid & st_q.reg_write & ~st_q.mem_read;
  assign fwd_reg   = st_q.dest_reg;
  assign fwd_data  = st_q.alu_result;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: each driven cycle pushes the expected
// MEM-stage state, which is popped and compared one edge later.
module tb_ex_mem_reg;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 0;
  logic          rst, stall, flush;
  logic          ex_valid, ex_zero, ex_reg_write, ex_mem_read, ex_mem_write;
  logic          ex_branch, ex_branch_ne;
  logic [DW-1:0] ex_alu_result, ex_store_data, ex_pc_plus4, ex_imm_sext;
  logic [RW-1:0] ex_dest_reg;
  logic          mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic          branch_taken, fwd_valid;
  logic [DW-1:0] mem_alu_result, mem_store_data, branch_target, fwd_data;
  logic [RW-1:0] mem_dest_reg, fwd_reg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [RW-1:0] dest;
    logic          rw, mr, mw, bt;
    logic [DW-1:0] tgt;
  } rec_t;

  rec_t mdl;
  rec_t sb[$];

  always #5 clk = ~clk;

  ex_mem_reg #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_zero(ex_zero),
    .ex_store_data(ex_store_data), .ex_dest_reg(ex_dest_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_branch_ne(ex_branch_ne), .ex_pc_plus4(ex_pc_plus4),
    .ex_imm_sext(ex_imm_sext),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_dest_reg(mem_dest_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare every output against one expected record.
  task automatic cmp_all(input string tag, input rec_t e);
    chk({tag, ".valid"}, DW'(mem_valid), DW'(e.valid));
    chk({tag, ".alu"},   mem_alu_result, e.alu);
    chk({tag, ".sd"},    mem_store_data, e.sd);
    chk({tag, ".dest"},  DW'(mem_dest_reg), DW'(e.dest));
    chk({tag, ".rw"},    DW'(mem_reg_write), DW'(e.rw));
    chk({tag, ".mr"},    DW'(mem_mem_read), DW'(e.mr));
    chk({tag, ".mw"},    DW'(mem_mem_write), DW'(e.mw));
    chk({tag, ".bt"},    DW'(branch_taken), DW'(e.bt));
    chk({tag, ".tgt"},   branch_target, e.tgt);
    chk({tag, ".fwdv"},  DW'(fwd_valid), DW'(e.valid & e.rw & ~e.mr));
    chk({tag, ".fwdr"},  DW'(fwd_reg), DW'(e.dest));
    chk({tag, ".fwdd"},  fwd_data, e.alu);
  endtask

  // Reference next state from the current EX inputs.
  function automatic rec_t model_next(input rec_t cur);
    rec_t r;
    logic [DW-1:0] off;
    if (flush) return '0;
    if (stall) return cur;
    off     = ex_imm_sext * 4;
    r.valid = ex_valid;
    r.alu   = ex_alu_result;
    r.sd    = ex_store_data;
    r.dest  = ex_dest_reg;
    r.rw    = ex_valid && ex_reg_write && ex_dest_reg != 0;
    r.mr    = ex_valid && ex_mem_read;
    r.mw    = ex_valid && ex_mem_write;
    if (!ex_valid || !ex_branch) r.bt = 0;
    else if (ex_branch_ne)       r.bt = !ex_zero;
    else                         r.bt = ex_zero;
    r.tgt   = ex_pc_plus4 + off;
    return r;
  endfunction

  task automatic set_in(input logic v, input logic [DW-1:0] alu, input logic z,
                        input logic [DW-1:0] sd, input logic [RW-1:0] d,
                        input logic rw, input logic mr, input logic mw,
                        input logic br, input logic bne,
                        input logic [DW-1:0] pc4, input logic [DW-1:0] imm);
    ex_valid = v; ex_alu_result = alu; ex_zero = z; ex_store_data = sd;
    ex_dest_reg = d; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_branch = br; ex_branch_ne = bne; ex_pc_plus4 = pc4; ex_imm_sext = imm;
  endtask

  task automatic rand_in();
    set_in($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
           RW'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom, $urandom);
  endtask

  // One clock: push expectation, take the edge, pop and compare.
  task automatic cycle(input string tag);
    rec_t e;
    sb.push_back(model_next(mdl));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      cmp_all(tag, e);
      mdl = e;
    end
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    rand_in();
    #1;
    cmp_all("rst_async", '0);
    repeat (3) begin
      @(posedge clk); #1; rand_in();
    end
    cmp_all("rst_hold", '0);
    rst = 0;
    mdl = '0;
    cmp_all("rst_rel", '0);

    // ADD r8 = 5
    set_in(1, 32'h5, 0, 32'h0, 5'd8, 1, 0, 0, 0, 0, 32'h40, 32'h0);
    cycle("add");
    chk("add.fwdv_lit", DW'(fwd_valid), 1);
    // write to $0 suppressed
    set_in(1, 32'h7, 0, 32'h0, 5'd0, 1, 0, 0, 0, 0, 32'h44, 32'h0);
    cycle("r0");
    chk("r0.rw_lit", DW'(mem_reg_write), 0);
    // LW r9: not forwardable
    set_in(1, 32'h1000, 0, 32'h0, 5'd9, 1, 1, 0, 0, 0, 32'h48, 32'h0);
    cycle("lw");
    chk("lw.fwdv_lit", DW'(fwd_valid), 0);
    // BEQ taken, negative offset
    set_in(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 1, 0, 32'h100, 32'hFFFF_FFFE);
    cycle("beq");
    chk("beq.tgt_lit", branch_target, 32'h0000_00F8);
    chk("beq.bt_lit", DW'(branch_taken), 1);
    // BNE not taken with zero=1, then taken with zero=0
    set_in(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 1, 1, 32'h200, 32'h10);
    cycle("bne_nt");
    set_in(1, 32'h3, 0, 32'h0, 5'd0, 0, 0, 0, 1, 1, 32'h200, 32'h10);
    cycle("bne_t");
    // target wraps modulo 2^DW
    set_in(1, 32'h0, 1, 32'h0, 5'd0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h2);
    cycle("wrap");
    chk("wrap.tgt_lit", branch_target, 32'h4);

    // SW then hold under stall while inputs change
    set_in(1, 32'h2000, 0, 32'hDEAD_BEEF, 5'd4, 0, 0, 1, 0, 0, 32'h60, 32'h8);
    cycle("sw");
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      cycle("stall");
    end
    chk("stall.sd_lit", mem_store_data, 32'hDEAD_BEEF);
    flush = 1;
    cycle("flush_stall");
    flush = 0; stall = 0;

    // Bubble: controls gated off, data still captured
    set_in(0, 32'h55, 1, 32'h66, 5'd3, 1, 1, 1, 1, 0, 32'h80, 32'h1);
    cycle("bubble");
    // Illegal read+write passes both through
    set_in(1, 32'h77, 0, 32'h88, 5'd5, 1, 1, 1, 0, 0, 32'h90, 32'h0);
    cycle("rdwr");

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      rand_in();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end
    stall = 0; flush = 0;

    // Async reset pulse between edges after a real capture
    set_in(1, 32'h1234, 0, 32'h5678, 5'd12, 1, 0, 1, 1, 1, 32'h300, 32'h4);
    cycle("pre_rst");
    #2 rst = 1;
    #1 cmp_all("rst_mid", '0);
    #1 rst = 0;
    mdl = '0;
    // Reset during stall also clears, and capture resumes after release
    set_in(1, 32'hABCD, 0, 32'h1, 5'd7, 1, 0, 0, 0, 0, 32'h400, 32'h1);
    cycle("post_rst");
    stall = 1;
    #2 rst = 1;
    #1 cmp_all("rst_stall", '0);
    #1 rst = 0;
    mdl = '0;
    stall = 0;
    cycle("resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
